// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared types and constants for the fetch sequencer
package fetch_sequencer_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF = 32'd4;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} fetch_state_e;
endpackage

// File: rtl/fetch_sequencer_hold_buf.sv
// fetch_hold_buf: (pc, instr) capture register used while decode is stalled
module fetch_hold_buf
  import fetch_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr
);
  logic [2*XLEN-1:0] r_data;
  // capture on load, clear on reset or when the held word is consumed/dropped
  always_ff @(posedge clk)
    if (rst || i_clear) r_data <= '0;
    else if (i_load) r_data <= {i_pc, i_instr};
  assign {o_pc, o_instr} = r_data;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing and instruction-memory handshake for the fetch stage
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            stall_f
);
  fetch_state_e r_state, w_next_state;
  logic [XLEN-1:0] r_fetch_pc, r_pending_pc, w_next_pc, w_next_pending;
  logic [XLEN-1:0] w_buf_pc, w_buf_instr;
  logic w_load, w_clear;
  fetch_hold_buf u_hold_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_clear(w_clear),
    .i_pc   (r_fetch_pc),
    .i_instr(imem_rdata),
    .o_pc   (w_buf_pc),
    .o_instr(w_buf_instr)
  );
  // state, fetch address and post-discard redirect target
  always_ff @(posedge clk)
    if (rst) begin
      r_state      <= FETCH;
      r_fetch_pc   <= RESET_PC;
      r_pending_pc <= '0;
    end else begin
      r_state      <= w_next_state;
      r_fetch_pc   <= w_next_pc;
      r_pending_pc <= w_next_pending;
    end
  // next state and outputs; redirect outranks stall and any same-cycle transfer
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_fetch_pc;
    w_next_pending = r_pending_pc;
    w_load         = 1'b0;
    w_clear        = 1'b0;
    imem_req       = 1'b0;
    imem_addr      = r_fetch_pc;
    instr          = '0;
    pc             = '0;
    instr_valid    = 1'b0;
    if (!rst)
      unique case (r_state)
        FETCH, WAIT: begin
          imem_req = 1'b1;
          instr    = imem_rdata;
          pc       = r_fetch_pc;
          if (redirect_valid) begin
            if (r_state == WAIT && !imem_ready) begin
              w_next_pending = redirect_pc;
              w_next_state   = DISCARD;
            end else begin
              w_next_pc    = redirect_pc;
              w_next_state = FETCH;
            end
          end else if (imem_ready && stall_d) begin
            w_load       = 1'b1;
            w_next_state = HOLD;
          end else if (imem_ready) begin
            instr_valid  = 1'b1;
            w_next_pc    = r_fetch_pc + PC_STEP;
            w_next_state = FETCH;
          end else w_next_state = WAIT;
        end
        HOLD: begin
          instr = w_buf_instr;
          pc    = w_buf_pc;
          if (redirect_valid) begin
            w_clear      = 1'b1;
            w_next_pc    = redirect_pc;
            w_next_state = FETCH;
          end else if (!stall_d) begin
            instr_valid  = 1'b1;
            w_clear      = 1'b1;
            w_next_pc    = r_fetch_pc + PC_STEP;
            w_next_state = FETCH;
          end
        end
        DISCARD: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            w_next_pc    = redirect_valid ? redirect_pc : r_pending_pc;
            w_next_state = FETCH;
          end else if (redirect_valid) w_next_pending = redirect_pc;
        end
      endcase
  end
  assign stall_f = rst || !(instr_valid && !stall_d);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized run against a transaction-level model
module tb_fetch_sequencer;
  logic        clk, rst, stall_d, redirect_valid, imem_ready;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, pc, instr;
  logic        imem_req, instr_valid, stall_f;
  int checks = 0, errors = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall_d       (stall_d),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall_f       (stall_f)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic s, input logic red, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; stall_d = s; redirect_valid = red; redirect_pc = rp; imem_ready = rdy;
    #1;
  endtask

  task automatic do_reset;
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 32'h44, 1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL reset_stall_f: got %b want 1", stall_f); end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_sequential;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(4 * i)); end
      checks++; if (instr !== mem_word(32'(4 * i))) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, mem_word(32'(4 * i))); end
      checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL seq_stall_f[%0d]: got %b want 0", i, stall_f); end
    end
  endtask

  task automatic test_wait;
    do_reset;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want req=1 addr=8", i, imem_req, imem_addr); end
      checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL wait_stall_f[%0d]: got %b want 1", i, stall_f); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
    end
    cyc(0, 0, 0, 0, 1);
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL wait_deliver: got valid=%b pc=%h want valid=1 pc=8", instr_valid, pc); end
  endtask

  task automatic test_hold;
    int n;
    n = 0;
    do_reset;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    if (instr_valid && pc == 32'h10) n++;
    checks++; if (imem_addr !== 32'h10 || instr_valid !== 1'b0) begin errors++; $display("FAIL hold_capture: got addr=%h valid=%b want addr=10 valid=0", imem_addr, instr_valid); end
    cyc(0, 1, 0, 0, 1);
    if (instr_valid && pc == 32'h10) n++;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
    checks++; if (pc !== 32'h10 || instr !== mem_word(32'h10) || instr_valid !== 1'b0) begin errors++; $display("FAIL hold_stable: got pc=%h instr=%h valid=%b want pc=10 instr=%h valid=0", pc, instr, instr_valid, mem_word(32'h10)); end
    cyc(0, 0, 0, 0, 1);
    if (instr_valid && pc == 32'h10) n++;
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h10 || instr !== mem_word(32'h10)) begin errors++; $display("FAIL hold_release: got valid=%b pc=%h instr=%h want valid=1 pc=10", instr_valid, pc, instr); end
    cyc(0, 0, 0, 0, 0);
    if (instr_valid && pc == 32'h10) n++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("FAIL hold_next: got req=%b addr=%h want req=1 addr=14", imem_req, imem_addr); end
    checks++; if (n !== 1) begin errors++; $display("FAIL hold_once: got %0d deliveries want 1", n); end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL rw_addr: got %h want 20", imem_addr); end
    cyc(0, 0, 1, 32'h400, 0);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_redirect_valid: got %b want 0", instr_valid); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL rw_held_addr: got req=%b addr=%h want req=1 addr=20", imem_req, imem_addr); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (imem_addr !== 32'h20 || instr_valid !== 1'b0) begin errors++; $display("FAIL rw_drop: got addr=%h valid=%b want addr=20 valid=0", imem_addr, instr_valid); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (imem_addr !== 32'h400 || instr_valid !== 1'b1 || pc !== 32'h400) begin errors++; $display("FAIL rw_target: got addr=%h valid=%b pc=%h want addr=400 valid=1 pc=400", imem_addr, instr_valid, pc); end
  endtask

  task automatic test_redirect_transfer;
    do_reset;
    cyc(0, 1, 1, 32'h80, 1);
    checks++; if (instr_valid !== 1'b0 || stall_f !== 1'b1) begin errors++; $display("FAIL rt_valid: got valid=%b stall_f=%b want valid=0 stall_f=1", instr_valid, stall_f); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b1) begin errors++; $display("FAIL rt_next: got req=%b addr=%h valid=%b want req=1 addr=80 valid=1", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_wrap_and_reset;
    do_reset;
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 1);
    checks++; if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_deliver: got valid=%b pc=%h want valid=1 pc=fffffffc", instr_valid, pc); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_wait_addr: got %h want 4", imem_addr); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midwait_rst_req: got %b want 0", imem_req); end
    cyc(0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midwait_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
  endtask

  // model: next sequential address, an optional parked instruction, an outstanding
  // request that has already waited, and a squashed request with its deferred target
  task automatic test_random;
    logic [31:0] m_pc, m_held_pc, m_target, rp, e_pc;
    logic m_held, m_waited, m_squash, r, s, red, rdy, e_req, e_valid, e_sf;
    do_reset;
    m_pc = 32'h0; m_held = 0; m_waited = 0; m_squash = 0; m_held_pc = 0; m_target = 0;
    for (int k = 0; k < 3000; k++) begin
      r   = $urandom_range(0, 99) == 0;
      s   = $urandom_range(0, 3) == 0;
      red = $urandom_range(0, 7) == 0;
      rp  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      rdy = $urandom_range(0, 9) < 6;
      cyc(r, s, red, rp, rdy);
      e_pc = 32'h0;
      if (r) begin
        e_req = 0; e_valid = 0;
      end else if (m_held) begin
        e_req = 0; e_valid = !red && !s; e_pc = m_held_pc;
      end else begin
        e_req = 1; e_valid = rdy && !red && !m_squash && !s; e_pc = m_pc;
      end
      e_sf = r || !(e_valid && !s);
      checks++; if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", k, imem_req, e_req); end
      checks++; if (instr_valid !== e_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, instr_valid, e_valid); end
      checks++; if (stall_f !== e_sf) begin errors++; $display("FAIL rnd_stall_f[%0d]: got %b want %b", k, stall_f, e_sf); end
      if (e_req) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, imem_addr, m_pc); end
      end
      if (r || e_valid || m_held) begin
        checks++; if (pc !== e_pc || instr !== (r ? 32'h0 : mem_word(e_pc))) begin errors++; $display("FAIL rnd_data[%0d]: got pc=%h instr=%h want pc=%h", k, pc, instr, e_pc); end
      end
      if (r) begin
        m_pc = 32'h0; m_held = 0; m_waited = 0; m_squash = 0;
      end else if (m_held) begin
        if (red) begin m_pc = rp; m_held = 0; end
        else if (!s) begin m_pc = m_held_pc + 32'd4; m_held = 0; end
      end else if (m_squash) begin
        if (rdy) begin m_pc = red ? rp : m_target; m_squash = 0; m_waited = 0; end
        else if (red) m_target = rp;
      end else if (red) begin
        if (m_waited && !rdy) begin m_squash = 1; m_target = rp; end
        else m_pc = rp;
        m_waited = 0;
      end else if (rdy) begin
        if (s) begin m_held = 1; m_held_pc = m_pc; end
        else m_pc = m_pc + 32'd4;
        m_waited = 0;
      end else m_waited = 1;
    end
  endtask

  initial begin
    rst = 1; stall_d = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 0;
    test_reset;
    test_sequential;
    test_wait;
    test_hold;
    test_redirect_wait;
    test_redirect_transfer;
    test_wrap_and_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
